// File: rtl/scoped_write_arbiter_pkg.sv
// Package: scoped_arb_pkg
// Purpose: shared constants and types for the scoped write arbiter.
//   - Target-select codes carried on each requester's 2-bit addr slice.
//   - Encoding of the arbiter FSM state.
//   - Helper that tells whether a target-select code names a real register.
package scoped_arb_pkg;

  // Target-select codes.
  localparam logic [1:0] ADDR_X   = 2'd0;
  localparam logic [1:0] ADDR_Y   = 2'd1;
  localparam logic [1:0] ADDR_Z   = 2'd2;
  localparam logic [1:0] ADDR_INV = 2'd3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // True when the select code names x, y or z.
  function automatic logic addr_valid(input logic [1:0] a);
    return a != ADDR_INV;
  endfunction

endpackage

// File: rtl/scoped_write_arbiter_rr_pick.sv
// Module: rr_pick
// Purpose: combinational round-robin selector. Scans the request vector
//   starting at 'pointer' and wrapping modulo NREQ; the first set bit wins.
// Ports:
//   req     in  NREQ  request vector
//   pointer in  IW    index with highest priority this round
//   winner  out NREQ  one-hot winner (all zero when no request)
//   index   out IW    binary index of the winner (0 when no request)
//   any     out 1     at least one request is present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            any
);

  int pos;

  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    pos    = 0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate position for this priority slot, wrapped into 0..NREQ-1.
      pos = int'(pointer) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos]) begin
        any         = 1'b1;
        winner[pos] = 1'b1;
        index       = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/scoped_write_arbiter.sv
// Module: scoped_write_arbiter
// Purpose: round-robin arbiter sharing one write path between NREQ
//   requesters. Each transaction commits at most one write into one of the
//   scoped target registers x, y, z, and answers the requester with either
//   an ack (write done) or an err (invalid target, no write).
//
// Handshake: a requester raises req[i] with addr/data slices valid and holds
//   all three until it sees ack[i] or err[i] (a one-cycle pulse), then drops
//   req[i] on the following cycle. A req still high in the IDLE cycle after
//   the response is a new request. Dropping req[i] while granted (GRANT
//   cycle) aborts the transaction silently.
//
// Ports:
//   clk   in  1           rising-edge clock
//   rst   in  1           synchronous active-high reset
//   req   in  NREQ        per-requester level request
//   addr  in  2*NREQ      per-requester target select, slice i = addr[2i+1:2i]
//   data  in  WIDTH*NREQ  per-requester write data, slice i = data[WIDTH*i +: WIDTH]
//   gnt   out NREQ        registered one-hot grant
//   ack   out NREQ        one-cycle pulse: write committed for requester i
//   err   out NREQ        one-cycle pulse: requester i targeted addr 3
//   busy  out 1           FSM not in IDLE
//   x_q   out WIDTH       target register x
//   y_q   out WIDTH       target register y
//   z_q   out WIDTH       target register z
module scoped_write_arbiter
  import scoped_arb_pkg::*;
#(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_X = '0,
  parameter logic [WIDTH-1:0] RST_Y = '0,
  parameter logic [WIDTH-1:0] RST_Z = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     addr,
  input  logic [WIDTH*NREQ-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  output logic                  busy,
  output logic [WIDTH-1:0]      x_q,
  output logic [WIDTH-1:0]      y_q,
  output logic [WIDTH-1:0]      z_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [IW-1:0]    pointer;   // highest-priority requester for the next pick
  logic [IW-1:0]    gidx;      // index of the granted requester
  logic [1:0]       sel_addr;  // target captured in GRANT
  logic [WIDTH-1:0] sel_data;  // data captured in GRANT

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_index;
  logic             pick_any;

  logic [1:0]       cur_addr;  // granted requester's live addr slice
  logic [WIDTH-1:0] cur_data;  // granted requester's live data slice

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req     (req),
    .pointer (pointer),
    .winner  (pick_onehot),
    .index   (pick_index),
    .any     (pick_any)
  );

  // Only the granted requester's slices are looked at, so activity on the
  // other requesters' inputs cannot disturb an in-flight transaction.
  always_comb begin
    cur_addr = addr[2*int'(gidx) +: 2];
    cur_data = data[WIDTH*int'(gidx) +: WIDTH];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ack      <= '0;
      err      <= '0;
      pointer  <= '0;
      gidx     <= '0;
      sel_addr <= ADDR_X;
      sel_data <= '0;
      x_q      <= RST_X;
      y_q      <= RST_Y;
      z_q      <= RST_Z;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          err <= '0;
          if (pick_any) begin
            gnt   <= pick_onehot;
            gidx  <= pick_index;
            state <= GRANT;
          end
        end

        GRANT: begin
          sel_addr <= cur_addr;
          sel_data <= cur_data;
          if (req[gidx]) begin
            // The response is registered here so it is visible exactly
            // during the COMMIT cycle.
            state <= COMMIT;
            if (addr_valid(cur_addr)) ack <= gnt;
            else                      err <= gnt;
          end else begin
            // Requester withdrew: abandon without touching the pointer.
            gnt   <= '0;
            state <= IDLE;
          end
        end

        COMMIT: begin
          case (sel_addr)
            ADDR_X:  x_q <= sel_data;
            ADDR_Y:  y_q <= sel_data;
            ADDR_Z:  z_q <= sel_data;
            default: ;
          endcase
          ack     <= '0;
          err     <= '0;
          gnt     <= '0;
          // Served requester drops to lowest priority next round.
          pointer <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          state   <= IDLE;
        end

        default: begin
          gnt   <= '0;
          ack   <= '0;
          err   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the outputs.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_ack_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_err_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(err));
  a_ack_err_ex : assert property (@(posedge clk) disable iff (rst) (ack & err) == '0);

endmodule

// File: tb/tb_scoped_write_arbiter.sv
// Testbench for scoped_write_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
module tb_scoped_write_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam logic [W-1:0] RST_X = 8'h00;
  localparam logic [W-1:0] RST_Y = 8'h5A;
  localparam logic [W-1:0] RST_Z = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_r  = '0;
  logic [2*NREQ-1:0] addr_r = '0;
  logic [W*NREQ-1:0] data_r = '0;
  logic [NREQ-1:0]   gnt, ack, err;
  logic              busy;
  logic [W-1:0]      x_q, y_q, z_q;

  scoped_write_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (W),
    .RST_X (RST_X),
    .RST_Y (RST_Y),
    .RST_Z (RST_Z)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req_r),
    .addr (addr_r),
    .data (data_r),
    .gnt  (gnt),
    .ack  (ack),
    .err  (err),
    .busy (busy),
    .x_q  (x_q),
    .y_q  (y_q),
    .z_q  (z_q)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] m_reg [3];   // x, y, z
  int           m_ptr;
  int           checks = 0;
  int           fails  = 0;
  logic [W-1:0] exp_q[$];    // expected x/y/z triple after each commit

  task automatic m_reset();
    m_reg[0] = RST_X;
    m_reg[1] = RST_Y;
    m_reg[2] = RST_Z;
    m_ptr    = 0;
  endtask

  // First requesting index scanning ptr, ptr+1, ... modulo NREQ.
  function automatic int pick(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // ---------------- driver / checking ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".x_q"}, 32'(x_q), 32'(m_reg[0]));
    chk({tag, ".y_q"}, 32'(y_q), 32'(m_reg[1]));
    chk({tag, ".z_q"}, 32'(z_q), 32'(m_reg[2]));
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [W-1:0] d);
    req_r[i]         = 1'b1;
    addr_r[2*i +: 2] = a;
    data_r[W*i +: W] = d;
  endtask

  // One transaction, called in an IDLE cycle with at least one req set.
  // Returns the index the model expects to be served.
  task automatic txn(input bit abort_it, output int w);
    logic [1:0]   a;
    logic [W-1:0] d;
    w = pick(m_ptr, req_r);
    if (w < 0) begin
      chk("txn_no_request", 32'(req_r), 32'hFFFF_FFFF);
      return;
    end
    a = addr_r[2*w +: 2];
    d = data_r[W*w +: W];
    step();  // GRANT
    chk("gnt_grant", 32'(gnt), 32'(1) << w);
    chk("busy_grant", 32'(busy), 32'd1);
    chk("ack_grant", 32'(ack | err), 32'd0);
    // Disturb every other requester's inputs while this one is in flight.
    for (int i = 0; i < NREQ; i++) begin
      if (i != w) begin
        addr_r[2*i +: 2] = 2'($urandom_range(0, 3));
        data_r[W*i +: W] = W'($urandom_range(0, 255));
      end
    end
    if (abort_it) begin
      req_r[w] = 1'b0;
      step();  // back in IDLE, nothing committed
      chk("gnt_abort", 32'(gnt), 32'd0);
      chk("busy_abort", 32'(busy), 32'd0);
      chk("resp_abort", 32'(ack | err), 32'd0);
      check_regs("abort");
      return;
    end
    step();  // COMMIT
    chk("gnt_commit", 32'(gnt), 32'(1) << w);
    if (a == 2'd3) begin
      chk("err_commit", 32'(err), 32'(1) << w);
      chk("ack_commit", 32'(ack), 32'd0);
    end else begin
      chk("ack_commit", 32'(ack), 32'(1) << w);
      chk("err_commit", 32'(err), 32'd0);
      m_reg[a] = d;
    end
    m_ptr = (w + 1) % NREQ;
    exp_q.push_back(m_reg[0]);
    exp_q.push_back(m_reg[1]);
    exp_q.push_back(m_reg[2]);
    step();  // IDLE, register update visible
    chk("x_after", 32'(x_q), 32'(exp_q.pop_front()));
    chk("y_after", 32'(y_q), 32'(exp_q.pop_front()));
    chk("z_after", 32'(z_q), 32'(exp_q.pop_front()));
    chk("gnt_idle", 32'(gnt), 32'd0);
    chk("resp_idle", 32'(ack | err), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    req_r[w] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w;
    m_reset();

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_regs("reset");
    chk("reset.gnt", 32'(gnt), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.resp", 32'(ack | err), 32'd0);

    // Single write of 42 to x by requester 1.
    set_req(1, 2'd0, 8'h42);
    txn(1'b0, w);
    chk("single.winner", 32'(w), 32'd1);
    chk("single.x", 32'(x_q), 32'h42);

    // Fresh reset so the rotation starts at requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    check_regs("reset2");

    // Fairness: all four held, served 0,1,2,3.
    set_req(0, 2'd0, 8'h43);
    set_req(1, 2'd1, 8'h44);
    set_req(2, 2'd2, 8'h45);
    set_req(3, 2'd2, 8'h46);
    for (int i = 0; i < NREQ; i++) begin
      // Keep the remaining requesters' payloads stable for this scenario.
      logic [2*NREQ-1:0] a_keep;
      logic [W*NREQ-1:0] d_keep;
      a_keep = {2'd2, 2'd2, 2'd1, 2'd0};
      d_keep = {8'h46, 8'h45, 8'h44, 8'h43};
      addr_r = a_keep;
      data_r = d_keep;
      txn(1'b0, w);
      chk("fair.order", 32'(w), 32'(i));
    end
    chk("fair.y", 32'(y_q), 32'h44);
    chk("fair.z", 32'(z_q), 32'h46);

    // Invalid target from requester 2.
    set_req(2, 2'd3, 8'hFF);
    txn(1'b0, w);
    chk("inv.winner", 32'(w), 32'd2);
    chk("inv.ptr", 32'(m_ptr), 32'd3);

    // Abort: requester 0 withdraws during GRANT.
    set_req(0, 2'd1, 8'h77);
    txn(1'b1, w);
    chk("abort.winner", 32'(w), 32'd0);
    // Requesters 0 and 1 together: pointer still 3, so 0 wins.
    set_req(0, 2'd1, 8'h11);
    set_req(1, 2'd2, 8'h22);
    txn(1'b0, w);
    chk("after_abort.winner", 32'(w), 32'd0);
    txn(1'b0, w);
    chk("after_abort.next", 32'(w), 32'd1);

    // Reset during COMMIT of a z write.
    req_r = '0;
    set_req(2, 2'd2, 8'h44);
    step();
    chk("midrst.gnt", 32'(gnt), 32'b0100);
    step();
    chk("midrst.ack", 32'(ack), 32'b0100);
    rst   = 1'b1;
    req_r = '0;
    step();
    rst = 1'b0;
    m_reset();
    check_regs("midrst");
    chk("midrst.gnt0", 32'(gnt), 32'd0);
    chk("midrst.busy0", 32'(busy), 32'd0);
    chk("midrst.ack0", 32'(ack | err), 32'd0);
    step();
    step();
    chk("midrst.quiet", 32'(ack | err | gnt), 32'd0);
    check_regs("midrst_hold");

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_r[i] && $urandom_range(0, 1) == 1)
          set_req(i, 2'($urandom_range(0, 3)), W'($urandom_range(0, 255)));
      if (req_r == '0)
        set_req(int'($urandom_range(0, NREQ - 1)), 2'($urandom_range(0, 3)),
                W'($urandom_range(0, 255)));
      txn($urandom_range(0, 5) == 0, w);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
